// File: rtl/reg_scoreboard.sv
// reg_scoreboard
//   Tracks destination registers of in-flight instructions between issue and
//   writeback, and raises a read-after-write stall for decode.
//
//   Ports
//     clk, rst_n           clock, asynchronous active-low reset
//     issue_valid/we/rd    issuing instruction and its destination register
//     src_rs, src_rt       source registers of the instruction in decode
//     wb_valid, wb_rd      writeback of the oldest tracked instruction
//     stall                RAW hazard on a source, or queue full
//     full, empty, count   writeback queue occupancy
//     head_rd              destination of the oldest entry (0 when empty)
//     err                  sticky {mismatch, underflow, overflow}
module reg_scoreboard #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       issue_valid,
  input  logic                       issue_we,
  input  logic [4:0]                 issue_rd,
  input  logic [4:0]                 src_rs,
  input  logic [4:0]                 src_rt,
  input  logic                       wb_valid,
  input  logic [4:0]                 wb_rd,
  output logic                       stall,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [4:0]                 head_rd,
  output logic [2:0]                 err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]    q_mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] pend_q [32];
  logic [CW-1:0] pend_d [32];
  logic [2:0]    err_q, err_d;

  logic push_req, push_ok, pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head_rd = empty ? 5'd0 : q_mem_q[rd_ptr_q];
  assign err     = err_q;

  assign push_req = issue_valid && issue_we && (issue_rd != 5'd0);
  assign pop      = wb_valid && !empty;
  // A pop in the same cycle frees a slot, so a push is accepted even at full.
  assign push_ok  = push_req && (!full || pop);

  assign stall = ((src_rs != 5'd0) && (pend_q[src_rs] != '0)) ||
                 ((src_rt != 5'd0) && (pend_q[src_rt] != '0)) ||
                 full;

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CW'(push_ok) - CW'(pop);

    err_d = err_q;
    if (pop && (wb_rd != head_rd))   err_d[2] = 1'b1;
    if (wb_valid && empty)           err_d[1] = 1'b1;
    if (push_req && !push_ok)        err_d[0] = 1'b1;

    // Push and pop of the same register cancel out.
    for (int i = 0; i < 32; i++) begin
      pend_d[i] = pend_q[i] + CW'(push_ok && (issue_rd == 5'(i)))
                            - CW'(pop && (head_rd == 5'(i)));
    end
    pend_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= '0;
      for (int i = 0; i < DEPTH; i++) q_mem_q[i] <= '0;
      for (int i = 0; i < 32; i++)    pend_q[i]  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      if (push_ok) q_mem_q[wr_ptr_q] <= issue_rd;
      for (int i = 0; i < 32; i++) pend_q[i] <= pend_d[i];
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       issue_valid, issue_we;
  logic [4:0] issue_rd, src_rs, src_rt, wb_rd;
  logic       wb_valid;
  logic       stall, full, empty;
  logic [2:0] count;
  logic [4:0] head_rd;
  logic [2:0] err;

  int checks = 0;
  int errors = 0;

  reg_scoreboard #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_rd(issue_rd),
    .src_rs(src_rs), .src_rt(src_rt),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .stall(stall), .full(full), .empty(empty), .count(count),
    .head_rd(head_rd), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_we = 0; issue_rd = 0; wb_valid = 0; wb_rd = 0;
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_valid = 1; issue_we = 1; issue_rd = rd;
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_stall"}, 32'(stall), 0);
    check({pfx, "_full"},  32'(full),  0);
    check({pfx, "_empty"}, 32'(empty), 1);
    check({pfx, "_count"}, 32'(count), 0);
    check({pfx, "_head"},  32'(head_rd), 0);
    check({pfx, "_err"},   32'(err), 0);
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] model_q[$];
    logic       do_pop;

    rst_n = 0; idle(); src_rs = 0; src_rt = 0;
    #12;
    check_reset("rst");
    step();
    rst_n = 1;
    step();

    // single RAW hazard on rs
    issue(5); src_rs = 5;
    step();
    idle();
    check("raw_stall",  32'(stall), 1);
    check("raw_count",  32'(count), 1);
    check("raw_head",   32'(head_rd), 5);
    wb_valid = 1; wb_rd = 5;
    step();
    idle();
    check("wb_stall",   32'(stall), 0);
    check("wb_count",   32'(count), 0);
    check("wb_empty",   32'(empty), 1);

    // two in-flight writers of the same register
    src_rs = 0; src_rt = 3;
    issue(3); step(); step();
    idle(); wb_valid = 1; wb_rd = 3;
    step();
    idle();
    check("dup_stall",  32'(stall), 1);
    check("dup_count",  32'(count), 1);
    wb_valid = 1; wb_rd = 3;
    step();
    idle();
    check("dup_clear",  32'(stall), 0);
    check("dup_count0", 32'(count), 0);

    // rd=0 and non-writing instructions are not tracked
    src_rt = 0;
    issue(0); step();
    issue_we = 0; issue_rd = 7; step();
    idle();
    check("nowr_count", 32'(count), 0);
    check("nowr_empty", 32'(empty), 1);
    check("r0_stall",   32'(stall), 0);

    // fill, overflow, push at full with pop
    for (int i = 1; i <= 4; i++) begin
      issue(5'(i)); step();
    end
    idle(); src_rs = 10; src_rt = 11;
    check("fill_full",  32'(full), 1);
    check("fill_stall", 32'(stall), 1);
    check("fill_count", 32'(count), 4);
    check("fill_head",  32'(head_rd), 1);
    issue(9); step();
    idle();
    check("ovf_err",    32'(err), 3'b001);
    check("ovf_count",  32'(count), 4);
    check("ovf_head",   32'(head_rd), 1);
    issue(9); wb_valid = 1; wb_rd = 1; step();
    idle();
    check("pp_count",   32'(count), 4);
    check("pp_head",    32'(head_rd), 2);
    check("pp_err",     32'(err), 3'b001);
    src_rs = 9;
    check("pp_pend9",   32'(stall), 1);

    // mismatched writeback still pops the head
    src_rs = 0; src_rt = 0;
    wb_valid = 1; wb_rd = 6; step();
    idle();
    check("mm_head",    32'(head_rd), 3);
    check("mm_count",   32'(count), 3);
    check("mm_err",     32'(err), 3'b101);
    check("mm_nofull",  32'(stall), 0);
    wb_valid = 1; wb_rd = 3; step();
    wb_rd = 4; step();
    wb_rd = 9; step();
    idle();
    check("drain_count", 32'(count), 0);
    wb_valid = 1; wb_rd = 2; step();
    idle();
    check("udf_err",    32'(err), 3'b111);
    check("udf_count",  32'(count), 0);
    check("udf_empty",  32'(empty), 1);

    // ten pushes with interleaved pops; pointers wrap several times
    for (int i = 0; i < 10; i++) begin
      do_pop = (i >= 2);
      issue(5'(11 + i));
      if (do_pop) begin
        wb_valid = 1; wb_rd = model_q[0];
      end
      step();
      idle();
      if (do_pop) void'(model_q.pop_front());
      model_q.push_back(5'(11 + i));
      check($sformatf("wrap_head%0d", i),  32'(head_rd), 32'(model_q[0]));
      check($sformatf("wrap_count%0d", i), 32'(count), 32'(model_q.size()));
    end
    check("wrap_err",   32'(err), 3'b111);

    // asynchronous reset mid-stream, away from a clock edge
    issue(25); src_rs = 19; src_rt = 20;
    @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    idle(); src_rs = 19; src_rt = 20;
    check_reset("arst");
    #10;
    check("arst_hold",  32'(stall), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
